countdown_timer: RTL
====================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter: WIDTH, default 8, counter width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  tick enable; count decrements only on cycles with en=1.
REQ-005 load  input  1  single-cycle request: load load_value into count and reload register.
REQ-006 load_value  input  WIDTH  value captured when load=1.
REQ-007 start  input  1  single-cycle request: begin counting down.
REQ-008 stop  input  1  single-cycle request: halt counting, count held.
REQ-009 auto_reload  input  1  1 = reload from reload register on expiry and keep running; sampled on the expiry cycle.
REQ-010 count  output  WIDTH  current count value, registered.
REQ-011 busy  output  1  1 while in RUN state, registered.
REQ-012 expire  output  1  one-cycle pulse, registered, marking expiry.

Function
REQ-013 Two states, IDLE and RUN; busy SHALL equal (state == RUN).
REQ-014 Internal reload register, WIDTH bits; written only by load.
REQ-015 load=1 (any state): count <= load_value and reload <= load_value next edge; state unchanged unless REQ-022 applies.
REQ-016 IDLE, start=1, stop=0, load=0, count != 0: state -> RUN next edge; count unchanged on that edge.
REQ-017 IDLE, start=1, count == 0: ignored; state stays IDLE, expire stays 0.
REQ-018 IDLE, start=1 and load=1 in the same cycle: load applied; start applied only if load_value != 0 (state -> RUN).
REQ-019 RUN, en=1, count > 1, no load/stop: count <= count - 1.
REQ-020 RUN, en=1, count == 1, no load/stop: expire=1 on next cycle; auto_reload=0 -> count <= 0, state -> IDLE; auto_reload=1 -> count <= reload, state stays RUN.
REQ-021 RUN, en=0: count held; no expire.
REQ-022 RUN, load=1: load takes priority over decrement, no expire that cycle; if load_value == 0, state -> IDLE.
REQ-023 RUN, stop=1: state -> IDLE, count held at current value, no decrement, no expire; stop has priority over start, en and expiry.
REQ-024 stop=1 and load=1 same cycle: both applied (count loaded, state IDLE).
REQ-025 start=1 while in RUN: no effect.
REQ-026 stop=1 while in IDLE: no effect.
REQ-027 expire SHALL be high for exactly one cycle per expiry and low otherwise; back-to-back expiries possible only with reload == 1 and en held high (pulse every cycle).
REQ-028 Count SHALL never wrap below 0; no decrement occurs at count == 0.
REQ-029 Latency: count update, busy and expire visible one clock after the causing input cycle.

Reset
REQ-030 rst_n=0 SHALL immediately (asynchronously) force state=IDLE, count=0, reload=0, busy=0, expire=0.
REQ-031 Reset asserted mid-count SHALL discard the run; after release the block waits in IDLE for load/start.
REQ-032 Reset release is synchronous to clk by the integrator; the block samples inputs from the first rising edge with rst_n=1.

Verification
REQ-033 WIDTH=8; load 3, start, en=1 constant -> count 3,2,1,0; expire one pulse with count=0; busy falls same cycle.
REQ-034 auto_reload=1, load 2, start, en=1 -> count 2,1,2,1,2...; expire pulses every 2 cycles; busy stays 1.
REQ-035 load 5, start, en toggling 1/0 -> count decrements only on en=1 cycles; expire after 5 enabled ticks.
REQ-036 load 4, start, stop after 2 ticks -> count holds 2, busy=0, no expire; start again -> resumes 2,1,0 with expire.
REQ-037 RUN at count 1 with load=1, load_value=7 same cycle -> count=7, no expire, busy=1; load 0 in RUN -> IDLE, no expire.
REQ-038 rst_n pulsed low mid-count (between edges) -> count=0, busy=0, expire=0 immediately; start with count 0 afterwards ignored.

Source files
------------

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/stop control, optional auto-reload and a
// one-cycle expire pulse when the count runs out.
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expire
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reload, reload_nxt, count_nxt;
  logic             expire_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      expire <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      reload <= reload_nxt;
      expire <= expire_nxt;
    end
  end

  assign busy = (state == RUN);

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload;
    expire_nxt = 1'b0;

    // load always lands, whatever else happens this cycle
    if (load) begin
      count_nxt  = load_value;
      reload_nxt = load_value;
    end

    unique case (state)
      IDLE: begin
        // with a simultaneous load, the freshly loaded value decides
        if (start && !stop && (load ? (load_value != ZERO) : (count != ZERO)))
          state_nxt = RUN;
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (load) begin
          if (load_value == ZERO) state_nxt = IDLE;
        end else if (en) begin
          if (count > ONE) begin
            count_nxt = count - ONE;
          end else if (count == ONE) begin
            expire_nxt = 1'b1;
            if (auto_reload) begin
              count_nxt = reload;
            end else begin
              count_nxt = ZERO;
              state_nxt = IDLE;
            end
          end else begin
            // count 0 while running is unreachable; fall back to idle safely
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
